mux16_rr_arbiter: RTL and testbench



---
 rtl/mux16_rr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mux16_rr_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 32-bit 16:1 mux (code 4'b1111 = idle).
// Define MUX16_ARB_TIMEOUT_EN to add the hold counter that forcibly revokes long grants.
module mux16_rr_arbiter #(
  parameter int N_REQ    = 15,
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] req,
  output logic [14:0] gnt,
  output logic [3:0]  select,
  output logic        valid,
  output logic        timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [3:0]  IDLE_SEL  = 4'b1111;
  localparam logic [3:0]  LAST_INIT = 4'(N_REQ - 1);
  localparam logic [14:0] REQ_MASK  = 15'((32'd1 << N_REQ) - 32'd1);

  if (N_REQ < 1 || N_REQ > 15 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
    $error("mux16_rr_arbiter: N_REQ must be 1..15 and MAX_HOLD 2..255");
  end

  // Returns {found, index}: first set bit scanning upward from ptr+1, wrapping at N_REQ.
  // The scan ends on ptr itself, so a still-requesting owner is picked only when alone.
  function automatic logic [4:0] rr_pick(input logic [14:0] r, input logic [3:0] ptr);
    logic       found;
    logic [3:0] idx;
    logic [4:0] cand;
    found = 1'b0;
    idx   = IDLE_SEL;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = 5'(ptr) + 5'(i);
      if (cand >= 5'(N_REQ)) begin
        cand = cand - 5'(N_REQ);
      end else begin
        cand = cand;
      end
      if (!found && r[cand[3:0]]) begin
        found = 1'b1;
        idx   = cand[3:0];
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  state_t      state_r, state_n;
  logic [3:0]  last_r, last_n;
  logic [3:0]  sel_r, sel_n;
  logic [14:0] gnt_r, gnt_n;
  logic        valid_r;
  logic [14:0] masked_s;
  logic [3:0]  ptr_s;
  logic        owner_req_s;
  logic        pick_found_s;
  logic [3:0]  pick_idx_s;

  assign masked_s    = req & REQ_MASK;
  assign owner_req_s = |(masked_s & gnt_r);
  assign ptr_s       = (state_r == GRANT) ? sel_r : last_r;
  assign {pick_found_s, pick_idx_s} = rr_pick(masked_s, ptr_s);

`ifdef MUX16_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
  logic [7:0] hold_r, hold_n;
  logic       tmo_r, tmo_n;
`endif

  // Next-state, next-owner and pointer update.
  always_comb begin
    state_n = state_r;
    last_n  = last_r;
    sel_n   = sel_r;
    gnt_n   = gnt_r;
`ifdef MUX16_ARB_TIMEOUT_EN
    hold_n  = hold_r;
    tmo_n   = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          state_n = GRANT;
          sel_n   = pick_idx_s;
          gnt_n   = 15'd1 << pick_idx_s;
`ifdef MUX16_ARB_TIMEOUT_EN
          hold_n  = 8'd0;
`endif
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (!owner_req_s) begin
          last_n = sel_r;
          if (pick_found_s) begin
            sel_n = pick_idx_s;
            gnt_n = 15'd1 << pick_idx_s;
`ifdef MUX16_ARB_TIMEOUT_EN
            hold_n = 8'd0;
`endif
          end else begin
            state_n = IDLE;
            sel_n   = IDLE_SEL;
            gnt_n   = 15'd0;
          end
        end
`ifdef MUX16_ARB_TIMEOUT_EN
        // Owner still set in masked_s, so the pick falls back to it when nobody else waits.
        else if (hold_r == HOLD_LIM) begin
          tmo_n  = 1'b1;
          last_n = sel_r;
          sel_n  = pick_idx_s;
          gnt_n  = 15'd1 << pick_idx_s;
          hold_n = 8'd0;
        end else begin
          hold_n = hold_r + 8'd1;
        end
`else
        else begin
          state_n = GRANT;
        end
`endif
      end
      default: begin
        state_n = IDLE;
        sel_n   = IDLE_SEL;
        gnt_n   = 15'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      last_r  <= LAST_INIT;
      sel_r   <= IDLE_SEL;
      gnt_r   <= 15'd0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_n;
      last_r  <= last_n;
      sel_r   <= sel_n;
      gnt_r   <= gnt_n;
      valid_r <= (state_n == GRANT);
    end
  end

`ifdef MUX16_ARB_TIMEOUT_EN
  // Hold counter and timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r <= 8'd0;
      tmo_r  <= 1'b0;
    end else begin
      hold_r <= hold_n;
      tmo_r  <= tmo_n;
    end
  end
  assign timeout = tmo_r;
`else
  assign timeout = 1'b0;
`endif

  assign gnt    = gnt_r;
  assign select = sel_r;
  assign valid  = valid_r;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed self-checking bench for mux16_rr_arbiter: a full-width instance and an N_REQ=4 instance.
module tb_mux16_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] req, req4;
  logic [14:0] gnt, gnt4;
  logic [3:0]  select, select4;
  logic        valid, valid4, timeout, timeout4;

  int checks = 0;
  int errors = 0;

  mux16_rr_arbiter #(.N_REQ(15), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .select(select), .valid(valid), .timeout(timeout)
  );

  mux16_rr_arbiter #(.N_REQ(4), .MAX_HOLD(16)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .gnt(gnt4),
    .select(select4), .valid(valid4), .timeout(timeout4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input int idx);
    check({tag, "_sel"}, 32'(select), 32'(idx));
    check({tag, "_gnt"}, 32'(gnt), 32'(15'd1 << idx));
    check({tag, "_valid"}, 32'(valid), 32'd1);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_sel"}, 32'(select), 32'hF);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
  endtask

  initial begin
    rst  = 1'b1;
    req  = 15'd0;
    req4 = 15'd0;
    #3;
    expect_idle("reset");
    check("reset_tmo", 32'(timeout), 32'd0);
    check("reset4_valid", 32'(valid4), 32'd0);
    tick();
    rst = 1'b0;

    // Single requester 5: one-cycle latency, stable hold, release to idle
    req = 15'h0020;
    tick();
    expect_grant("single", 5);
    repeat (3) tick();
    check("single_hold", 32'(select), 32'd5);
    req = 15'd0;
    tick();
    expect_idle("single_rel");

    // Rotation with last=5: 0,1,2,0 with no idle cycle between owners
    req = 15'h0007;
    tick();
    expect_grant("rot0", 0);
    tick();
    req = 15'h0006;
    tick();
    expect_grant("rot1", 1);
    req = 15'h0007;
    tick();
    req = 15'h0005;
    tick();
    expect_grant("rot2", 2);
    req = 15'h0007;
    tick();
    req = 15'h0003;
    tick();
    expect_grant("rot3", 0);
    req = 15'd0;
    tick();
    expect_idle("rot_end");

    // Pointer wrap: make last=14, then 0 beats 14, then 14 follows
    req = 15'h4000;
    tick();
    expect_grant("wrap_set", 14);
    req = 15'd0;
    tick();
    req = 15'h4001;
    tick();
    expect_grant("wrap0", 0);
    req = 15'h4000;
    tick();
    expect_grant("wrap14", 14);
    req = 15'd0;
    tick();
    expect_idle("wrap_end");

    // Asynchronous reset mid-grant with owner 3
    req = 15'h0008;
    tick();
    expect_grant("pre_rst", 3);
    #1 rst = 1'b1;
    #1;
    expect_idle("async_rst");
    #1 rst = 1'b0;
    req = 15'h0009;
    tick();
    expect_grant("post_rst", 0);
    req = 15'd0;
    tick();

    // Masking on the N_REQ=4 instance
    req4 = 15'h0010;
    tick();
    check("mask_gnt", 32'(gnt4), 32'd0);
    tick();
    check("mask_valid", 32'(valid4), 32'd0);
    check("mask_sel", 32'(select4), 32'hF);
    req4 = 15'h0018;
    tick();
    check("mask_g3_sel", 32'(select4), 32'd3);
    check("mask_g3_gnt", 32'(gnt4), 32'h0008);
    req4 = 15'd0;

`ifdef MUX16_ARB_TIMEOUT_EN
    // last=0: 2 wins, is revoked after 4 grant cycles in favour of 6
    req = 15'h0044;
    tick();
    expect_grant("to_g2", 2);
    repeat (3) begin
      tick();
      check("to_hold_sel", 32'(select), 32'd2);
      check("to_hold_tmo", 32'(timeout), 32'd0);
    end
    tick();
    check("to_move_sel", 32'(select), 32'd6);
    check("to_move_tmo", 32'(timeout), 32'd1);
    req = 15'h0004;
    tick();
    check("to_back_sel", 32'(select), 32'd2);
    check("to_back_tmo", 32'(timeout), 32'd0);
    for (int rep = 0; rep < 2; rep++) begin
      repeat (3) begin
        tick();
        check("to_solo_tmo0", 32'(timeout), 32'd0);
      end
      tick();
      check("to_solo_tmo1", 32'(timeout), 32'd1);
      check("to_solo_sel", 32'(select), 32'd2);
    end
`else
    // Without the timeout feature a grant is held indefinitely
    req = 15'h0044;
    tick();
    expect_grant("hold_g2", 2);
    repeat (20) begin
      tick();
      check("hold_sel", 32'(select), 32'd2);
      check("hold_tmo", 32'(timeout), 32'd0);
    end
    req = 15'h0040;
    tick();
    expect_grant("hold_next", 6);
`endif
    req = 15'd0;
    tick();
    tick();
    expect_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
